// File: rtl/tlc_apb_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tlc_apb_sequencer: APB master that steps a two-road traffic-light slave.  Rev 1.0
// ----------------------------------------------------------------------------
module tlc_apb_sequencer #(
  parameter int CNT_W   = 16,
  parameter int DWELL_G = 100,
  parameter int DWELL_Y = 20,
  parameter int DWELL_R = 10,
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        enable,
  input  logic        clr_err,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata,
  output logic [2:0]  phase,
  output logic [2:0]  light_a,
  output logic [2:0]  light_b,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_SYNC_SETUP  = 3'd0,
    ST_SYNC_ACCESS = 3'd1,
    ST_WAIT        = 3'd2,
    ST_W_SETUP     = 3'd3,
    ST_W_ACCESS    = 3'd4,
    ST_R_SETUP     = 3'd5,
    ST_R_ACCESS    = 3'd6,
    ST_ERROR       = 3'd7
  } state_t;

  localparam logic [31:0] ADDR_STATE = 32'h0000_0000;
  localparam logic [31:0] ADDR_CTRL  = 32'h0000_0004;
  localparam logic [31:0] CODE_P0    = 32'h0001_0004;
  localparam logic [31:0] CODE_P1    = 32'h0001_0002;
  localparam logic [31:0] CODE_RED   = 32'h0001_0001;
  localparam logic [31:0] CODE_P3    = 32'h0004_0001;
  localparam logic [31:0] CODE_P4    = 32'h0002_0001;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SLVERR   = 2'd1;
  localparam logic [1:0] ERR_MISMATCH = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [31:0] phase_code(input logic [2:0] p);
    case (p)
      3'd0:    phase_code = CODE_P0;
      3'd1:    phase_code = CODE_P1;
      3'd3:    phase_code = CODE_P3;
      3'd4:    phase_code = CODE_P4;
      default: phase_code = CODE_RED;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dwell_load(input logic [2:0] p);
    case (p)
      3'd0, 3'd3: dwell_load = CNT_W'(DWELL_G - 1);
      3'd1, 3'd4: dwell_load = CNT_W'(DWELL_Y - 1);
      default:    dwell_load = CNT_W'(DWELL_R - 1);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             gap_q, gap_d;
  logic             nudge_q, nudge_d;
  logic             sync_retry_q, sync_retry_d;
  logic [2:0]       light_a_q, light_a_d;
  logic [2:0]       light_b_q, light_b_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [2:0] sync_phase;
  logic       sync_hit;
  logic       tmo_expired;

  assign tmo_expired = (tmo_q == TMO_LAST);

  // Unambiguous codes seen on a SYNC read; all-red is handled separately.
  always_comb begin
    sync_hit   = 1'b1;
    sync_phase = 3'd0;
    case (prdata)
      CODE_P0: sync_phase = 3'd0;
      CODE_P1: sync_phase = 3'd1;
      CODE_P3: sync_phase = 3'd3;
      CODE_P4: sync_phase = 3'd4;
      default: sync_hit   = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    gap_d        = 1'b0;
    nudge_d      = nudge_q;
    sync_retry_d = sync_retry_q;
    light_a_d    = light_a_q;
    light_b_d    = light_b_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    psel         = 1'b0;
    penable      = 1'b0;
    pwrite       = 1'b0;
    paddr        = ADDR_STATE;

    case (state_q)
      ST_SYNC_SETUP: begin
        // gap_q marks the mandatory idle cycle after a completed transfer
        if (!gap_q && enable) begin
          psel    = 1'b1;
          tmo_d   = '0;
          state_d = ST_SYNC_ACCESS;
        end
      end

      ST_SYNC_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          if (pslverr) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_SLVERR;
          end else if (sync_hit) begin
            phase_d   = sync_phase;
            light_a_d = prdata[2:0];
            light_b_d = prdata[18:16];
            cnt_d     = dwell_load(sync_phase);
            state_d   = ST_WAIT;
          end else if (prdata == CODE_RED && !sync_retry_q) begin
            sync_retry_d = 1'b1;
            nudge_d      = 1'b1;
            gap_d        = 1'b1;
            state_d      = ST_W_SETUP;
          end else begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_MISMATCH;
          end
        end else if (tmo_expired) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + CNT_ONE;
        end
      end

      ST_WAIT: begin
        if (enable) begin
          if (cnt_q == '0) begin
            state_d = ST_W_SETUP;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      ST_W_SETUP: begin
        if (!gap_q) begin
          psel    = 1'b1;
          pwrite  = 1'b1;
          paddr   = ADDR_CTRL;
          tmo_d   = '0;
          state_d = ST_W_ACCESS;
        end
      end

      ST_W_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = ADDR_CTRL;
        if (pready) begin
          if (pslverr) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_SLVERR;
            nudge_d    = 1'b0;
          end else if (nudge_q) begin
            // Write issued only to leave an ambiguous all-red: resync afterwards
            nudge_d = 1'b0;
            gap_d   = 1'b1;
            state_d = ST_SYNC_SETUP;
          end else begin
            phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
            gap_d   = 1'b1;
            state_d = ST_R_SETUP;
          end
        end else if (tmo_expired) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          nudge_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + CNT_ONE;
        end
      end

      ST_R_SETUP: begin
        if (!gap_q) begin
          psel    = 1'b1;
          tmo_d   = '0;
          state_d = ST_R_ACCESS;
        end
      end

      ST_R_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          if (pslverr) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_SLVERR;
          end else if (prdata != phase_code(phase_q)) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_MISMATCH;
          end else begin
            light_a_d = prdata[2:0];
            light_b_d = prdata[18:16];
            cnt_d     = dwell_load(phase_q);
            state_d   = ST_WAIT;
          end
        end else if (tmo_expired) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + CNT_ONE;
        end
      end

      ST_ERROR: begin
        if (clr_err) begin
          err_d        = 1'b0;
          err_code_d   = ERR_NONE;
          sync_retry_d = 1'b0;
          nudge_d      = 1'b0;
          state_d      = ST_SYNC_SETUP;
        end
      end

      default: state_d = ST_SYNC_SETUP;
    endcase
  end

  // gap_q starts set so no transfer is visible while presetn is low
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= ST_SYNC_SETUP;
      phase_q      <= 3'd0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      gap_q        <= 1'b1;
      nudge_q      <= 1'b0;
      sync_retry_q <= 1'b0;
      light_a_q    <= 3'd0;
      light_b_q    <= 3'd0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      nudge_q      <= nudge_d;
      sync_retry_q <= sync_retry_d;
      light_a_q    <= light_a_d;
      light_b_q    <= light_b_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign pwdata   = {31'd0, pwrite};
  assign phase    = phase_q;
  assign light_a  = light_a_q;
  assign light_b  = light_b_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign busy     = psel;

endmodule
`default_nettype wire

// File: tb/tb_tlc_apb_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tlc_apb_sequencer: directed bench for tlc_apb_sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_tlc_apb_sequencer;

  logic        pclk = 1'b0;
  logic        presetn, enable, clr_err;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [2:0]  phase, light_a, light_b;
  logic        err, busy;
  logic [1:0]  err_code;

  logic        slv_rdy, slv_err, slv_ovr, slv_load;
  logic [31:0] slv_word;
  logic [2:0]  slv_st, slv_load_val;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 pclk = ~pclk;

  tlc_apb_sequencer #(
    .CNT_W(16), .DWELL_G(4), .DWELL_Y(2), .DWELL_R(1), .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .presetn(presetn), .enable(enable), .clr_err(clr_err),
    .paddr(paddr), .pwdata(pwdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .phase(phase), .light_a(light_a), .light_b(light_b),
    .err(err), .err_code(err_code), .busy(busy)
  );

  function automatic logic [31:0] slv_code(input logic [2:0] s);
    case (s)
      3'd0:    slv_code = 32'h0001_0004;
      3'd1:    slv_code = 32'h0001_0002;
      3'd3:    slv_code = 32'h0004_0001;
      3'd4:    slv_code = 32'h0002_0001;
      default: slv_code = 32'h0001_0001;
    endcase
  endfunction

  // Traffic-light slave: advances one phase per accepted CTRL write
  assign pready  = slv_rdy;
  assign pslverr = slv_err;
  assign prdata  = slv_ovr ? slv_word : slv_code(slv_st);

  always @(posedge pclk) begin
    if (slv_load) slv_st <= slv_load_val;
    else if (psel && penable && pready && pwrite && !pslverr)
      slv_st <= (slv_st == 3'd5) ? 3'd0 : slv_st + 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  // Counts WAIT cycles from the first WAIT sample until the write SETUP shows up
  task automatic run_wait(input int hold_len, output int cnt);
    cnt = 0;
    while (!psel && cnt < 200) begin
      if (hold_len > 0 && cnt == 1) enable = 1'b0;
      if (hold_len > 0 && cnt == 1 + hold_len) enable = 1'b1;
      step();
      cnt++;
    end
    enable = 1'b1;
  endtask

  // From a write SETUP sample: write, readback, then the next WAIT
  task automatic do_cycle(input logic [2:0] ph, input logic [2:0] la, input logic [2:0] lb,
                          input int wexp, input int hold_len);
    int w;
    chk("w_setup_psel", psel, 1);
    chk("w_setup_pen", penable, 0);
    chk("w_setup_pwrite", pwrite, 1);
    chk("w_setup_paddr", paddr, 32'h4);
    chk("w_setup_pwdata", pwdata, 32'h1);
    step();
    chk("w_access_pen", {psel, penable, pwrite}, 3'b111);
    step();
    chk("gap_psel", psel, 0);
    chk("phase", phase, ph);
    step();
    chk("r_setup", {psel, penable, pwrite}, 3'b100);
    chk("r_setup_paddr", paddr, 32'h0);
    step();
    chk("r_access_pen", penable, 1);
    step();
    chk("light_a", light_a, la);
    chk("light_b", light_b, lb);
    chk("err_clear", err, 0);
    chk("busy_idle", busy, 0);
    run_wait(hold_len, w);
    chk("wait_len", w, wexp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0; enable = 1'b0; clr_err = 1'b0;
    slv_rdy = 1'b1; slv_err = 1'b0; slv_ovr = 1'b0; slv_word = 32'h0;
    slv_load = 1'b1; slv_load_val = 3'd0;
    repeat (3) step();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_phase", phase, 0);
    chk("rst_light_a", light_a, 0);
    chk("rst_light_b", light_b, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_busy", busy, 0);

    presetn = 1'b1; enable = 1'b1; slv_load = 1'b0;
    step();
    chk("sync_setup", {psel, penable, pwrite}, 3'b100);
    chk("sync_paddr", paddr, 32'h0);
    step();
    chk("sync_access", penable, 1);
    step();
    chk("sync_phase", phase, 0);
    chk("sync_light_a", light_a, 3'b100);
    chk("sync_light_b", light_b, 3'b001);
    chk("sync_idle", psel, 0);
    run_wait(0, n);
    chk("wait_g0", n, 4);

    do_cycle(3'd1, 3'b010, 3'b001, 2, 0);
    do_cycle(3'd2, 3'b001, 3'b001, 1, 0);
    do_cycle(3'd3, 3'b001, 3'b100, 4, 0);
    do_cycle(3'd4, 3'b001, 3'b010, 2, 0);
    do_cycle(3'd5, 3'b001, 3'b001, 1, 0);
    do_cycle(3'd0, 3'b100, 3'b001, 4, 0);
    do_cycle(3'd1, 3'b010, 3'b001, 12, 10);

    // Slave error on the write
    slv_err = 1'b1;
    step();
    step();
    chk("slverr_psel", psel, 0);
    chk("slverr_err", {err, err_code}, 3'b101);
    chk("slverr_phase", phase, 1);
    slv_err = 1'b0;
    repeat (3) step();
    chk("slverr_hold", {psel, err, err_code}, 4'b0101);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_err", {err, err_code}, 0);
    chk("clr_sync_setup", {psel, penable, pwrite}, 3'b100);
    step();
    step();
    chk("resync_phase", phase, 1);
    chk("resync_light_a", light_a, 3'b010);
    run_wait(0, n);
    chk("resync_wait", n, 2);

    // PREADY timeout on the write
    slv_rdy = 1'b0;
    step();
    n = 0;
    while (penable && n < 40) begin
      step();
      n++;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_psel", psel, 0);
    chk("tmo_err", {err, err_code}, 3'b111);
    slv_rdy = 1'b1; slv_load = 1'b1; slv_load_val = 3'd0;
    step();
    slv_load = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    step();
    step();
    chk("tmo_resync_phase", phase, 0);
    chk("tmo_resync_la", light_a, 3'b100);
    run_wait(0, n);
    chk("tmo_resync_wait", n, 4);

    // Readback mismatch: slave reports phase 0 after the step to phase 1
    step();
    step();
    chk("mm_phase", phase, 1);
    slv_ovr = 1'b1; slv_word = 32'h0001_0004;
    step();
    step();
    step();
    chk("mm_err", {err, err_code}, 3'b110);
    chk("mm_light_a", light_a, 3'b100);
    chk("mm_psel", psel, 0);

    // SYNC sees all-red twice
    slv_word = 32'h0001_0001;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("red_sync_setup", {psel, pwrite}, 2'b10);
    step();
    step();
    chk("red_gap", psel, 0);
    step();
    chk("red_nudge_setup", {psel, penable, pwrite}, 3'b101);
    chk("red_nudge_paddr", paddr, 32'h4);
    step();
    step();
    chk("red_gap2", {psel, err}, 2'b00);
    step();
    chk("red_sync2_setup", {psel, pwrite}, 2'b10);
    step();
    chk("red_sync2_access", penable, 1);
    step();
    chk("red_err", {err, err_code}, 3'b110);

    // Reset pulse during a write ACCESS
    slv_ovr = 1'b0; slv_load = 1'b1; slv_load_val = 3'd0;
    step();
    slv_load = 1'b0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    step();
    step();
    run_wait(0, n);
    chk("pre_rst_wait", n, 4);
    slv_rdy = 1'b0;
    step();
    chk("pre_rst_access", {psel, penable, pwrite}, 3'b111);
    presetn = 1'b0;
    #1;
    chk("async_rst_bus", {psel, penable, pwrite, busy}, 4'b0000);
    chk("async_rst_paddr", paddr, 0);
    chk("async_rst_state", {phase, light_a, err}, 0);
    step();
    presetn = 1'b1; slv_rdy = 1'b1;
    step();
    chk("post_rst_sync", {psel, penable, pwrite}, 3'b100);
    step();
    step();
    chk("post_rst_phase", phase, 0);
    chk("post_rst_light_a", light_a, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
